// File: rtl/id_stage.sv
// RV32I decode stage: register read addressing, write-back bypass, immediate and
// control decode, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int unsigned X_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             if_id_valid_i,
    input  logic [X_LEN-1:0] if_id_pc_i,
    input  logic [31:0]      if_id_instr_i,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    input  logic [X_LEN-1:0] rs1_data_i,
    input  logic [X_LEN-1:0] rs2_data_i,
    input  logic             wb_reg_write_i,
    input  logic [4:0]       wb_rd_addr_i,
    input  logic [X_LEN-1:0] wb_data_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             id_ex_valid_o,
    output logic [X_LEN-1:0] id_ex_pc_o,
    output logic [X_LEN-1:0] id_ex_rs1_data_o,
    output logic [X_LEN-1:0] id_ex_rs2_data_o,
    output logic [X_LEN-1:0] id_ex_imm_o,
    output logic [4:0]       id_ex_rs1_addr_o,
    output logic [4:0]       id_ex_rs2_addr_o,
    output logic [4:0]       id_ex_rd_addr_o,
    output logic [6:0]       id_ex_opcode_o,
    output logic [2:0]       id_ex_funct3_o,
    output logic [6:0]       id_ex_funct7_o,
    output logic             id_ex_reg_write_o,
    output logic             id_ex_mem_read_o,
    output logic             id_ex_mem_write_o
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic             valid;
        logic [X_LEN-1:0] pc;
        logic [X_LEN-1:0] rs1_data;
        logic [X_LEN-1:0] rs2_data;
        logic [X_LEN-1:0] imm;
        logic [4:0]       rs1_addr;
        logic [4:0]       rs2_addr;
        logic [4:0]       rd_addr;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } id_ex_t;

    id_ex_t id_ex_d, id_ex_q;

    logic [6:0]        opcode;
    logic [4:0]        rs1, rs2, rd;
    logic signed [31:0] imm32;
    logic [X_LEN-1:0]  op1, op2;
    logic              reg_write, mem_read, mem_write;
    logic              rs1_used, rs2_used, hazard;

    assign opcode     = if_id_instr_i[6:0];
    assign rd         = if_id_instr_i[11:7];
    assign rs1        = if_id_instr_i[19:15];
    assign rs2        = if_id_instr_i[24:20];
    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    // The register file writes at the clock edge, so forward WB data into this cycle's read.
    always_comb begin
        op1 = rs1_data_i;
        op2 = rs2_data_i;
        if (wb_reg_write_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs1)) op1 = wb_data_i;
        if (wb_reg_write_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs2)) op2 = wb_data_i;
    end

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{if_id_instr_i[31]}}, if_id_instr_i[31:20]};
            OP_STORE:
                imm32 = {{20{if_id_instr_i[31]}}, if_id_instr_i[31:25], if_id_instr_i[11:7]};
            OP_BRANCH:
                imm32 = {{19{if_id_instr_i[31]}}, if_id_instr_i[31], if_id_instr_i[7],
                         if_id_instr_i[30:25], if_id_instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {if_id_instr_i[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{if_id_instr_i[31]}}, if_id_instr_i[31], if_id_instr_i[19:12],
                         if_id_instr_i[20], if_id_instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (opcode)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: reg_write = 1'b1;
            OP_LOAD: begin
                reg_write = 1'b1;
                mem_read  = 1'b1;
            end
            OP_STORE: mem_write = 1'b1;
            default: ;
        endcase
        reg_write = reg_write & if_id_valid_i & (rd != 5'd0);
        mem_read  = mem_read & if_id_valid_i;
        mem_write = mem_write & if_id_valid_i;
    end

    assign rs1_used = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    assign hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd_addr != 5'd0) &&
                    if_id_valid_i &&
                    ((rs1_used && (rs1 == id_ex_q.rd_addr)) || (rs2_used && (rs2 == id_ex_q.rd_addr)));

    assign stall_o = hazard & ~flush_i;

    // Flush and load-use bubbles both leave an all-zero ID/EX entry.
    always_comb begin
        id_ex_d = '0;
        if (!flush_i && !hazard) begin
            id_ex_d.valid     = if_id_valid_i;
            id_ex_d.pc        = if_id_pc_i;
            id_ex_d.rs1_data  = op1;
            id_ex_d.rs2_data  = op2;
            id_ex_d.imm       = X_LEN'(imm32);
            id_ex_d.rs1_addr  = rs1;
            id_ex_d.rs2_addr  = rs2;
            id_ex_d.rd_addr   = rd;
            id_ex_d.opcode    = opcode;
            id_ex_d.funct3    = if_id_instr_i[14:12];
            id_ex_d.funct7    = if_id_instr_i[31:25];
            id_ex_d.reg_write = reg_write;
            id_ex_d.mem_read  = mem_read;
            id_ex_d.mem_write = mem_write;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) id_ex_q <= '0;
        else          id_ex_q <= id_ex_d;
    end

    assign id_ex_valid_o     = id_ex_q.valid;
    assign id_ex_pc_o        = id_ex_q.pc;
    assign id_ex_rs1_data_o  = id_ex_q.rs1_data;
    assign id_ex_rs2_data_o  = id_ex_q.rs2_data;
    assign id_ex_imm_o       = id_ex_q.imm;
    assign id_ex_rs1_addr_o  = id_ex_q.rs1_addr;
    assign id_ex_rs2_addr_o  = id_ex_q.rs2_addr;
    assign id_ex_rd_addr_o   = id_ex_q.rd_addr;
    assign id_ex_opcode_o    = id_ex_q.opcode;
    assign id_ex_funct3_o    = id_ex_q.funct3;
    assign id_ex_funct7_o    = id_ex_q.funct7;
    assign id_ex_reg_write_o = id_ex_q.reg_write;
    assign id_ex_mem_read_o  = id_ex_q.mem_read;
    assign id_ex_mem_write_o = id_ex_q.mem_write;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; the register file is modelled as xN holding the value N.
module tb_id_stage;

    localparam int unsigned X_LEN = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             if_id_valid = 1'b0;
    logic [31:0]      if_id_pc = '0;
    logic [31:0]      if_id_instr = '0;
    logic [4:0]       rs1_addr, rs2_addr;
    logic [31:0]      rs1_data, rs2_data;
    logic             wb_reg_write = 1'b0;
    logic [4:0]       wb_rd_addr = '0;
    logic [31:0]      wb_data = '0;
    logic             flush = 1'b0;
    logic             stall;
    logic             id_ex_valid;
    logic [31:0]      id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]       id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
    logic [6:0]       id_ex_opcode, id_ex_funct7;
    logic [2:0]       id_ex_funct3;
    logic             id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rs1_data = 32'(rs1_addr);
    assign rs2_data = 32'(rs2_addr);

    id_stage #(.X_LEN(X_LEN)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_id_valid_i(if_id_valid), .if_id_pc_i(if_id_pc), .if_id_instr_i(if_id_instr),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .wb_reg_write_i(wb_reg_write), .wb_rd_addr_i(wb_rd_addr), .wb_data_i(wb_data),
        .flush_i(flush), .stall_o(stall),
        .id_ex_valid_o(id_ex_valid), .id_ex_pc_o(id_ex_pc),
        .id_ex_rs1_data_o(id_ex_rs1_data), .id_ex_rs2_data_o(id_ex_rs2_data),
        .id_ex_imm_o(id_ex_imm),
        .id_ex_rs1_addr_o(id_ex_rs1_addr), .id_ex_rs2_addr_o(id_ex_rs2_addr),
        .id_ex_rd_addr_o(id_ex_rd_addr),
        .id_ex_opcode_o(id_ex_opcode), .id_ex_funct3_o(id_ex_funct3), .id_ex_funct7_o(id_ex_funct7),
        .id_ex_reg_write_o(id_ex_reg_write), .id_ex_mem_read_o(id_ex_mem_read),
        .id_ex_mem_write_o(id_ex_mem_write)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
        if_id_valid = 1'b1;
        if_id_pc    = pc;
        if_id_instr = instr;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_id_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (id_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", id_ex_valid); end
        checks++; if (id_ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h exp 0", id_ex_pc); end
        checks++; if (id_ex_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %0h exp 0", id_ex_imm); end
        checks++; if ({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall); end
    endtask

    task automatic test_addi();
        issue(32'h10, 32'hFFF08193);
        checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL addi_rs1_addr got %0d exp 1", rs1_addr); end
        step();
        checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h exp 1", id_ex_valid); end
        checks++; if (id_ex_pc !== 32'h10) begin errors++; $display("FAIL addi_pc got %0h exp 10", id_ex_pc); end
        checks++; if (id_ex_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %0h exp ffffffff", id_ex_imm); end
        checks++; if (id_ex_rs1_data !== 32'd1) begin errors++; $display("FAIL addi_rs1_data got %0h exp 1", id_ex_rs1_data); end
        checks++; if (id_ex_rd_addr !== 5'd3) begin errors++; $display("FAIL addi_rd got %0d exp 3", id_ex_rd_addr); end
        checks++; if (id_ex_reg_write !== 1'b1) begin errors++; $display("FAIL addi_reg_write got %0h exp 1", id_ex_reg_write); end
        checks++; if (id_ex_mem_read !== 1'b0) begin errors++; $display("FAIL addi_mem_read got %0h exp 0", id_ex_mem_read); end
        checks++; if (id_ex_opcode !== 7'h13) begin errors++; $display("FAIL addi_opcode got %0h exp 13", id_ex_opcode); end
    endtask

    task automatic test_store();
        issue(32'h14, 32'hFE20AE23);
        checks++; if (rs2_addr !== 5'd2) begin errors++; $display("FAIL sw_rs2_addr got %0d exp 2", rs2_addr); end
        step();
        checks++; if (id_ex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got %0h exp fffffffc", id_ex_imm); end
        checks++; if (id_ex_mem_write !== 1'b1) begin errors++; $display("FAIL sw_mem_write got %0h exp 1", id_ex_mem_write); end
        checks++; if (id_ex_reg_write !== 1'b0) begin errors++; $display("FAIL sw_reg_write got %0h exp 0", id_ex_reg_write); end
        checks++; if (id_ex_rs2_data !== 32'd2) begin errors++; $display("FAIL sw_rs2_data got %0h exp 2", id_ex_rs2_data); end
        checks++; if (id_ex_funct3 !== 3'd2) begin errors++; $display("FAIL sw_funct3 got %0h exp 2", id_ex_funct3); end
        checks++; if (id_ex_funct7 !== 7'h7F) begin errors++; $display("FAIL sw_funct7 got %0h exp 7f", id_ex_funct7); end
    endtask

    task automatic test_decode_misc();
        // BEQ x1,x2,-4
        issue(32'h20, 32'hFE208EE3);
        step();
        checks++; if (id_ex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %0h exp fffffffc", id_ex_imm); end
        checks++; if (id_ex_reg_write !== 1'b0) begin errors++; $display("FAIL beq_reg_write got %0h exp 0", id_ex_reg_write); end
        // JAL x1,+8
        issue(32'h24, 32'h008000EF);
        step();
        checks++; if (id_ex_imm !== 32'h8) begin errors++; $display("FAIL jal_imm got %0h exp 8", id_ex_imm); end
        checks++; if (id_ex_reg_write !== 1'b1) begin errors++; $display("FAIL jal_reg_write got %0h exp 1", id_ex_reg_write); end
        // ADDI x0,x0,0 must not write
        issue(32'h28, 32'h00000013);
        step();
        checks++; if (id_ex_reg_write !== 1'b0) begin errors++; $display("FAIL nop_reg_write got %0h exp 0", id_ex_reg_write); end
        // unknown opcode
        issue(32'h2C, 32'hFFFFFFFF);
        step();
        checks++; if (id_ex_imm !== 32'h0) begin errors++; $display("FAIL unk_imm got %0h exp 0", id_ex_imm); end
        checks++; if ({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write} !== 3'b000) begin errors++; $display("FAIL unk_ctrl got %b exp 000", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}); end
        checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL unk_valid got %0h exp 1", id_ex_valid); end
        // invalid slot: LW decoded but not valid
        issue(32'h30, 32'h00012283);
        if_id_valid = 1'b0;
        step();
        checks++; if ({id_ex_valid, id_ex_reg_write, id_ex_mem_read} !== 3'b000) begin errors++; $display("FAIL inv_ctrl got %b exp 000", {id_ex_valid, id_ex_reg_write, id_ex_mem_read}); end
    endtask

    task automatic test_load_use();
        int stall_cycles;
        stall_cycles = 0;
        issue(32'h18, 32'h00012283);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_pre_stall got %0h exp 0", stall); end
        step();
        checks++; if ({id_ex_mem_read, id_ex_rd_addr} !== {1'b1, 5'd5}) begin errors++; $display("FAIL lw_capture got %0h exp 25", {id_ex_mem_read, id_ex_rd_addr}); end
        issue(32'h1C, 32'h00128333);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h exp 1", stall); end
        if (stall === 1'b1) stall_cycles++;
        step();
        checks++; if ({id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write} !== 4'b0000) begin errors++; $display("FAIL lu_bubble got %b exp 0000", {id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}); end
        checks++; if (id_ex_pc !== 32'h0) begin errors++; $display("FAIL lu_bubble_pc got %0h exp 0", id_ex_pc); end
        if (stall === 1'b1) stall_cycles++;
        step();
        checks++; if (stall_cycles != 1) begin errors++; $display("FAIL lu_stall_cycles got %0d exp 1", stall_cycles); end
        checks++; if ({id_ex_valid, id_ex_pc} !== {1'b1, 32'h1C}) begin errors++; $display("FAIL lu_add_pc got %0h exp 1_0000001c", {id_ex_valid, id_ex_pc}); end
        checks++; if ({id_ex_rs1_data, id_ex_rs2_data} !== {32'd5, 32'd1}) begin errors++; $display("FAIL lu_add_ops got %0h exp 0000000500000001", {id_ex_rs1_data, id_ex_rs2_data}); end
        checks++; if ({id_ex_rd_addr, id_ex_reg_write} !== {5'd6, 1'b1}) begin errors++; $display("FAIL lu_add_rd got %0h exp d", {id_ex_rd_addr, id_ex_reg_write}); end
    endtask

    task automatic test_bypass();
        issue(32'h1C, 32'h00128333);
        wb_reg_write = 1'b1;
        wb_rd_addr   = 5'd1;
        wb_data      = 32'hDEADBEEF;
        step();
        checks++; if (id_ex_rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rs2 got %0h exp deadbeef", id_ex_rs2_data); end
        checks++; if (id_ex_rs1_data !== 32'd5) begin errors++; $display("FAIL byp_rs1_keep got %0h exp 5", id_ex_rs1_data); end
        wb_rd_addr = 5'd0;
        step();
        checks++; if (id_ex_rs2_data !== 32'd1) begin errors++; $display("FAIL byp_x0 got %0h exp 1", id_ex_rs2_data); end
        wb_rd_addr = 5'd5;
        step();
        checks++; if ({id_ex_rs1_data, id_ex_rs2_data} !== {32'hDEADBEEF, 32'd1}) begin errors++; $display("FAIL byp_rs1 got %0h exp deadbeef00000001", {id_ex_rs1_data, id_ex_rs2_data}); end
        wb_reg_write = 1'b0;
        step();
        checks++; if (id_ex_rs1_data !== 32'd5) begin errors++; $display("FAIL byp_off got %0h exp 5", id_ex_rs1_data); end
    endtask

    task automatic test_flush_hazard();
        issue(32'h40, 32'h00012283);
        step();
        issue(32'h44, 32'h00128333);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %0h exp 0", stall); end
        step();
        flush = 1'b0;
        checks++; if ({id_ex_valid, id_ex_reg_write} !== 2'b00) begin errors++; $display("FAIL fl_kill got %b exp 00", {id_ex_valid, id_ex_reg_write}); end
        issue(32'h48, 32'h00012283);
        step();
        // LUI whose rs1 field equals the load rd: rs1 is unused, so no stall
        issue(32'h4C, 32'h000282B7);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lui_stall got %0h exp 0", stall); end
        step();
        checks++; if ({id_ex_valid, id_ex_reg_write, id_ex_rd_addr} !== {1'b1, 1'b1, 5'd5}) begin errors++; $display("FAIL lui_capture got %0h exp 65", {id_ex_valid, id_ex_reg_write, id_ex_rd_addr}); end
        checks++; if (id_ex_imm !== 32'h00028000) begin errors++; $display("FAIL lui_imm got %0h exp 28000", id_ex_imm); end
    endtask

    task automatic test_reset_mid();
        issue(32'h50, 32'h00128333);
        step();
        checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %0h exp 1", id_ex_valid); end
        rst_n = 1'b0;
        step();
        checks++; if ({id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm} !== '0) begin errors++; $display("FAIL rm_data got %0h exp 0", {id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm}); end
        checks++; if ({id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_opcode, id_ex_funct3, id_ex_funct7} !== '0) begin errors++; $display("FAIL rm_fields got %0h exp 0", {id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_opcode, id_ex_funct3, id_ex_funct7}); end
        checks++; if ({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, stall} !== 4'b0000) begin errors++; $display("FAIL rm_ctrl got %b exp 0000", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, stall}); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_decode_misc();
        test_load_use();
        test_bypass();
        test_flush_hazard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the 5-stage RV32I pipeline, sitting between the IF/ID register and EX.
- Drives register-file read addresses from the fetched instruction.
- Applies write-back bypass to the returned read data.
- Generates the immediate and control signals.
- Detects load-use hazards and owns the ID/EX pipeline register, with stall-bubble and flush.

Parameters:
X_LEN, 32, datapath width (immediates sign-extended to X_LEN).

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  reset, synchronous, active-low
if_id_valid_i  in  1  IF/ID holds a valid instruction
if_id_pc_i  in  X_LEN  PC of the instruction in ID
if_id_instr_i  in  32  instruction in ID
rs1_addr_o  out  5  register-file read address 1, equal to instr[19:15]
rs2_addr_o  out  5  register-file read address 2, equal to instr[24:20]
rs1_data_i  in  X_LEN  register-file read data 1
rs2_data_i  in  X_LEN  register-file read data 2
wb_reg_write_i  in  1  WB stage writes the register file this cycle
wb_rd_addr_i  in  5  WB destination register
wb_data_i  in  X_LEN  WB write data
flush_i  in  1  EX redirect (taken branch/jump); kill the instruction in ID
stall_o  out  1  hold PC and IF/ID (load-use hazard)
id_ex_valid_o  out  1  ID/EX holds a valid instruction
id_ex_pc_o  out  X_LEN  registered PC
id_ex_rs1_data_o  out  X_LEN  registered, bypassed operand 1
id_ex_rs2_data_o  out  X_LEN  registered, bypassed operand 2
id_ex_imm_o  out  X_LEN  registered immediate
id_ex_rs1_addr_o  out  5  registered rs1 (for EX forwarding)
id_ex_rs2_addr_o  out  5  registered rs2
id_ex_rd_addr_o  out  5  registered rd
id_ex_opcode_o  out  7  registered opcode
id_ex_funct3_o  out  3  registered funct3
id_ex_funct7_o  out  7  registered funct7
id_ex_reg_write_o  out  1  instruction writes rd
id_ex_mem_read_o  out  1  instruction is a load
id_ex_mem_write_o  out  1  instruction is a store

Behaviour:
Reset and address outputs:
- Reset (rst_n_i=0 at a clock edge) clears every id_ex_* output to 0. Reset mid-stream discards the ID/EX contents.
- rs1_addr_o and rs2_addr_o are combinational from if_id_instr_i and are never gated.

Bypass (combinational):
- If wb_reg_write_i=1, wb_rd_addr_i≠0 and wb_rd_addr_i==rs1, operand 1 = wb_data_i; otherwise operand 1 = rs1_data_i.
- rs2 is handled identically.
- This is required because the register file writes at the clock edge while reads are asynchronous.

Immediate generation (sign-extended from instr[31]):
- I-type (0010011, 0000011, 1100111): instr[31:20]
- S (0100011): {instr[31:25], instr[11:7]}
- B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U (0110111, 0010111): {instr[31:12], 12'b0}
- J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Any other opcode: 0

Control decode:
- reg_write = 1 for 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and only when rd≠0.
- mem_read = 1 for opcode 0000011.
- mem_write = 1 for opcode 0100011.
- Unknown opcode: all controls 0.
- When if_id_valid_i=0, all controls are 0.

Load-use hazard (combinational):
- hazard = id_ex_valid_o & id_ex_mem_read_o & id_ex_rd_addr_o≠0 & if_id_valid_i & (match_rs1 | match_rs2).
- match_rs1 requires rs1==id_ex_rd_addr_o and rs1 is used; rs1 is used by every opcode except 0110111, 0010111, 1101111.
- match_rs2 requires rs2==id_ex_rd_addr_o and rs2 is used; rs2 is used only by 0110011, 0100011, 1100011.
- stall_o = hazard & ~flush_i.

ID/EX register update, priority reset > flush > hazard > normal:
- Flush: id_ex_valid_o and all control outputs are cleared next cycle. Flush wins over a simultaneous hazard, so stall_o=0 in that case.
- Hazard: insert a bubble (valid and controls 0). IF/ID is held upstream via stall_o, so the same instruction is re-decoded next cycle. The hazard then clears, giving exactly 1 bubble per load-use.
- Normal: capture decoded fields, bypassed operands, and valid = if_id_valid_i.

Other:
- Latency: 1 cycle from IF/ID to ID/EX.
- Data fields of a bubble are don't-care but must not be X; zero them.

Test Plan:
- Reset then ADDI x3,x1,-1 (0xFFF08193, PC=0x10), no WB → next cycle id_ex_valid=1, imm=0xFFFFFFFF, rs1_data=1, rd=3, reg_write=1, mem_read=0.
- SW x2,-4(x1) (0xFE20AE23) → imm=0xFFFFFFFC, mem_write=1, reg_write=0, rs2_data=2.
- LW x5,0(x2) (0x00012283) followed by ADD x6,x5,x1 (0x00128333) → stall_o=1 for exactly 1 cycle, one bubble (valid=0, controls 0), then ADD captured with valid=1.
- ADD x6,x5,x1 in ID with wb_reg_write=1, wb_rd=1, wb_data=0xDEADBEEF → id_ex_rs2_data=0xDEADBEEF, rs1_data=5. Repeat with wb_rd=0 → no bypass.
- Load-use hazard with flush_i=1 in the same cycle → stall_o=0, next id_ex_valid=0. LUI x5 after LW x5 → no stall.
- rst_n_i=0 for 1 cycle while a valid ADD is in ID/EX → all id_ex_* = 0 next cycle, stall_o=0.
